mean_frame_ctrl: RTL
====================

Name: mean_frame_ctrl

Overview:
- Frame-level sequencer for the per-channel mean accumulator.
- Clears the accumulator before each frame and accepts a planar R, G, B pixel stream over a valid/ready handshake.
- Tags each pixel with its colour, drives the accumulator's valid/colour/value/last/size inputs, then waits for its finish flag.
- Captures the three means and hands them to the downstream white-balance gain stage over a valid/ready handshake.

Parameters:
- SIZE, 10, log2(pixels per plane) = n+m for an (2^n x 2^m) image; plane length N = 2^SIZE; legal range 1..20.

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset; asynchronous, active-high
- start_i  input  1  begin one frame; honoured in IDLE only
- pix_valid_i  input  1  pixel valid
- pix_data_i  input  8  pixel value
- pix_ready_o  output  1  pixel accepted when pix_valid_i & pix_ready_o
- mean_rst_n_o  output  1  active-low clear to the accumulator
- mean_valid_o  output  1  to accumulator valid_i
- mean_color_o  output  2  to accumulator color_i; 0=R, 1=G, 2=B
- mean_value_o  output  8  to accumulator value_i
- mean_last_o  output  1  to accumulator last_i; end of plane
- mean_size_o  output  5  to accumulator size_i; constant SIZE
- mean_finish_i  input  1  accumulator finish flag; sticky until cleared
- r_mean_i, g_mean_i, b_mean_i  input  8 each  accumulator means
- res_valid_o  output  1  result valid
- res_ready_i  input  1  downstream accepts result
- r_mean_o, g_mean_o, b_mean_o  output  8 each  captured means
- busy_o  output  1  high in any state except IDLE
- err_o  output  1  watchdog error flag; see Optional Feature

Behaviour:
- Reset state: FSM in IDLE, plane and pixel counters 0.
- Reset values: all outputs 0 except mean_rst_n_o=0 (accumulator held in clear) and mean_size_o=SIZE.
- mean_rst_n_o = ~rst & ~clr_r, where clr_r is the registered CLEAR-state flag.
- States: IDLE, CLEAR, STREAM, WAIT_FIN, DONE.
- IDLE: pix_ready_o=0. start_i=1 -> CLEAR. Otherwise stay.
- CLEAR: lasts exactly 1 cycle; mean_rst_n_o=0 for that cycle. Then -> STREAM with plane=0, pix_cnt=0.
- STREAM: pix_ready_o=1.
  - On accept: next cycle mean_valid_o=1, mean_value_o=pix_data_i, mean_color_o=plane. Latency is 1 cycle, fully registered.
  - mean_last_o=1 in the same output cycle as the pixel where pix_cnt==N-1.
  - On that pixel: pix_cnt wraps to 0 and plane increments.
  - With no accept, mean_valid_o=0 and mean_last_o=0; pix_valid_i gaps are allowed anywhere.
  - After the accept of plane-2 pixel N-1: pix_ready_o drops the next cycle, FSM -> WAIT_FIN.
  - Exactly 3*N pixels per frame. Extra valid input is held off by ready=0.
- WAIT_FIN: pix_ready_o=0.
  - On mean_finish_i=1, register r/g/b_mean_i into r/g/b_mean_o and go -> DONE.
  - The accumulator asserts finish 2 cycles after the third mean_last_o pulse; the sums are final on that same edge.
- DONE: res_valid_o=1 and the mean outputs are held stable until res_valid_o & res_ready_i. Then res_valid_o=0 next cycle, FSM -> IDLE.
- start_i is ignored outside IDLE, including DONE with a simultaneous res_ready_i.
- Counter widths: pix_cnt is SIZE bits and wraps naturally; plane is 2 bits and never reaches 3.
- Reset asserted mid-frame aborts to IDLE immediately and clears the accumulator via mean_rst_n_o. Partial sums are discarded.
- err_o is cleared on the transition CLEAR -> STREAM.

Optional Feature:
- Macro: MEAN_CTRL_WDOG_EN.
- Defined: WAIT_FIN runs a 6-bit cycle counter. If mean_finish_i is still 0 after 32 cycles, the FSM goes -> DONE with r/g/b_mean_o=0 and err_o=1, and err_o holds until the next CLEAR.
- Not defined: WAIT_FIN waits indefinitely, no counter is synthesised, and err_o is tied to 0.

Test Plan:
- SIZE=2, start pulse, 12 back-to-back pixels (R=4,8,12,16; G=all 100; B=0,0,0,4) with the accumulator model -> mean_last_o pulses at output pixels 4, 8 and 12; res_valid_o carries r=10, g=100, b=1.
- Same frame with a 3-cycle pix_valid_i gap after every pixel -> identical means; mean_valid_o count = 12 exactly; mean_color_o sequence 0x4, 1x4, 2x4.
- Two consecutive frames (second frame all 50) -> mean_rst_n_o low 1 cycle before each frame; second result 50, 50, 50 with no residue from frame 1.
- res_ready_i held 0 for 10 cycles in DONE, start_i pulsed meanwhile -> outputs stable, start ignored; FSM returns to IDLE one cycle after ready.
- rst asserted after 6 pixels -> all outputs at reset values asynchronously; a new start then produces a correct full result.
- MEAN_CTRL_WDOG_EN defined, mean_finish_i forced 0 -> DONE entered 32 cycles after entering WAIT_FIN with err_o=1 and means 0; err_o cleared at the next frame's STREAM.

Source files
------------

// File: rtl/mean_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mean_frame_ctrl
// Description : Frame sequencer for the per-channel mean accumulator. Clears
//               the accumulator, streams 3*2^SIZE planar R/G/B pixels into it
//               tagged with their colour, waits for its finish flag, then
//               offers the captured means downstream over valid/ready.
//               Optional WAIT_FIN watchdog: define MEAN_CTRL_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mean_frame_ctrl #(
  parameter int SIZE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       pix_valid_i,
  input  logic [7:0] pix_data_i,
  output logic       pix_ready_o,
  output logic       mean_rst_n_o,
  output logic       mean_valid_o,
  output logic [1:0] mean_color_o,
  output logic [7:0] mean_value_o,
  output logic       mean_last_o,
  output logic [4:0] mean_size_o,
  input  logic       mean_finish_i,
  input  logic [7:0] r_mean_i,
  input  logic [7:0] g_mean_i,
  input  logic [7:0] b_mean_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic [7:0] r_mean_o,
  output logic [7:0] g_mean_o,
  output logic [7:0] b_mean_o,
  output logic       busy_o,
  output logic       err_o
);

  localparam logic [SIZE-1:0] c_last_pix = '1;
  localparam logic [SIZE-1:0] c_one      = SIZE'(1);
  localparam logic [4:0]      c_size     = 5'(SIZE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_FIN = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_plane;
  logic [SIZE-1:0] r_pix_cnt;
  logic            r_clr;
  logic            r_mean_valid;
  logic [1:0]      r_mean_color;
  logic [7:0]      r_mean_value;
  logic            r_mean_last;
  logic [7:0]      r_r_mean;
  logic [7:0]      r_g_mean;
  logic [7:0]      r_b_mean;
  logic            w_accept;
  logic            w_pix_last;
  logic            w_timeout;

  assign w_accept   = pix_valid_i && (r_state == S_STREAM);
  assign w_pix_last = (r_pix_cnt == c_last_pix);

`ifdef MEAN_CTRL_WDOG_EN
  logic [5:0] r_wdog_cnt;
  logic       r_err;

  // Watchdog: count cycles spent in WAIT_FIN; flag sticks until the next CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wdog_cnt <= 6'd0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_WAIT_FIN) r_wdog_cnt <= r_wdog_cnt + 6'd1;
      else                       r_wdog_cnt <= 6'd0;
      if (r_state == S_CLEAR)    r_err <= 1'b0;
      else if (w_timeout)        r_err <= 1'b1;
    end
  end

  // 32nd WAIT_FIN cycle without finish forces the frame to DONE
  assign w_timeout = (r_state == S_WAIT_FIN) && !mean_finish_i && (r_wdog_cnt == 6'd31);
  assign err_o     = r_err;
`else
  assign w_timeout = 1'b0;
  assign err_o     = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode; start_i is only looked at in IDLE
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (start_i) w_state_nxt = S_CLEAR;
      S_CLEAR:    w_state_nxt = S_STREAM;
      S_STREAM:   if (w_accept && w_pix_last && (r_plane == 2'd2)) w_state_nxt = S_WAIT_FIN;
      S_WAIT_FIN: if (mean_finish_i || w_timeout) w_state_nxt = S_DONE;
      S_DONE:     if (res_ready_i) w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Pixel counters, registered accumulator drive and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_plane      <= 2'd0;
      r_pix_cnt    <= '0;
      r_clr        <= 1'b0;
      r_mean_valid <= 1'b0;
      r_mean_color <= 2'd0;
      r_mean_value <= 8'd0;
      r_mean_last  <= 1'b0;
      r_r_mean     <= 8'd0;
      r_g_mean     <= 8'd0;
      r_b_mean     <= 8'd0;
    end else begin
      r_clr        <= (w_state_nxt == S_CLEAR);
      r_mean_valid <= w_accept;
      r_mean_last  <= w_accept && w_pix_last;
      if (w_accept) begin
        r_mean_value <= pix_data_i;
        r_mean_color <= r_plane;
      end
      if (r_state == S_CLEAR) begin
        r_plane   <= 2'd0;
        r_pix_cnt <= '0;
      end else if (w_accept) begin
        r_pix_cnt <= r_pix_cnt + c_one;
        // plane 2 is the final one; wrap to 0 so the counter never reaches 3
        if (w_pix_last) r_plane <= (r_plane == 2'd2) ? 2'd0 : r_plane + 2'd1;
      end
      if (r_state == S_WAIT_FIN) begin
        if (mean_finish_i) begin
          r_r_mean <= r_mean_i;
          r_g_mean <= g_mean_i;
          r_b_mean <= b_mean_i;
        end else if (w_timeout) begin
          r_r_mean <= 8'd0;
          r_g_mean <= 8'd0;
          r_b_mean <= 8'd0;
        end
      end
    end
  end

  assign pix_ready_o  = (r_state == S_STREAM);
  assign mean_rst_n_o = ~rst & ~r_clr;
  assign mean_valid_o = r_mean_valid;
  assign mean_color_o = r_mean_color;
  assign mean_value_o = r_mean_value;
  assign mean_last_o  = r_mean_last;
  assign mean_size_o  = c_size;
  assign res_valid_o  = (r_state == S_DONE);
  assign r_mean_o     = r_r_mean;
  assign g_mean_o     = r_g_mean;
  assign b_mean_o     = r_b_mean;
  assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire
